// File: rtl/pipelined_cskip_adder.sv
// ---------------------------------------------------------------------------
// pipelined_cskip_adder
//
// Pipelined, parametrised carry-skip adder/subtractor with valid/ready flow
// control and a signed-overflow flag.
//
// The WIDTH-bit datapath is split into BLK-bit carry-skip blocks. Each block
// ripples internally and forms a block propagate P = &(a ^ b). The carry out
// of a block is the incoming block carry when P is set (skip path), otherwise
// the ripple carry. BLK_PER_STG blocks are evaluated per pipeline stage, and
// the result of every stage is registered, which gives NSTG = WIDTH /
// (BLK * BLK_PER_STG) stages.
//
// Ports
//   clk        in   1      rising-edge clock
//   rst_n      in   1      asynchronous active-low reset
//   in_valid   in   1      a, b, c_in and sub are valid
//   in_ready   out  1      stage 0 can accept an operation this cycle
//   a, b       in   WIDTH  operands
//   c_in       in   1      carry in; used in add mode only
//   sub        in   1      1: a - b (a + ~b + 1); 0: a + b + c_in
//   out_valid  out  1      s/cout/ovf hold a result
//   out_ready  in   1      consumer takes the result
//   s          out  WIDTH  sum or difference, modulo 2^WIDTH
//   cout       out  1      carry out of the MSB (subtract: 1 = no borrow)
//   ovf        out  1      signed overflow (carry into MSB ^ carry out of MSB)
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. A producer holding valid keeps its data stable until that edge.
// in_ready does not depend on in_valid, and out_valid does not depend on
// out_ready. While out_valid is high and out_ready low, out_valid, s, cout and
// ovf are held. Operations leave in the order they were accepted.
//
// Latency: an op accepted on edge n is presented on out_valid after edge
// n + NSTG - 1. With out_ready held high the pipe takes one op per cycle.
// ---------------------------------------------------------------------------
module pipelined_cskip_adder #(
    parameter int WIDTH       = 32,
    parameter int BLK         = 4,
    parameter int BLK_PER_STG = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             ovf
);

    // Bits resolved per stage, and the number of stages.
    localparam int SW   = BLK * BLK_PER_STG;
    localparam int NSTG = WIDTH / SW;
    // Operand registers are needed only between stages. The last stage has
    // no consumer of operand bits.
    localparam int OPN  = (NSTG > 1) ? NSTG - 1 : 1;

    // ------------------------------------------------------------------
    // Stage registers
    // ------------------------------------------------------------------
    logic [NSTG-1:0]  v_q;            // stage holds a live op
    logic [WIDTH-1:0] s_q   [NSTG];   // sum bits resolved so far
    logic [NSTG-1:0]  c_q;            // carry out of the resolved part
    logic             cm_q  [NSTG];   // carry into the top resolved bit
    logic [WIDTH-1:0] a_q   [OPN];    // operand A for the later stages
    logic [WIDTH-1:0] b_q   [OPN];    // operand B, already inverted for sub

    // ------------------------------------------------------------------
    // Stage inputs and next-state values
    // ------------------------------------------------------------------
    logic [NSTG-1:0]  src_v;
    logic [WIDTH-1:0] src_a [NSTG];
    logic [WIDTH-1:0] src_b [NSTG];
    logic [WIDTH-1:0] src_s [NSTG];
    logic [NSTG-1:0]  src_c;

    logic [WIDTH-1:0] nxt_s [NSTG];
    logic [NSTG-1:0]  nxt_c;
    logic [NSTG-1:0]  nxt_cm;

    logic [NSTG-1:0]  en;             // stage register may load this cycle
    logic [SW+1:0]    res;            // {carry into MSB, carry out, sum}

    // Subtraction is a + ~b + 1. The inversion is done once at entry, so
    // every later stage sees a plain addition.
    logic [WIDTH-1:0] b_eff;
    logic             c0;

    assign b_eff = sub ? ~b : b;
    assign c0    = sub ? 1'b1 : c_in;

    // ------------------------------------------------------------------
    // One stage worth of carry-skip addition.
    // Each block ripples from its incoming carry. The block carry-out is
    // taken from the skip mux: when every bit propagates, the incoming
    // carry passes straight through. Both paths agree logically. The mux
    // is kept so that the carry chain between blocks stays short.
    // Returns {carry into bit SW-1, carry out of the segment, sum}.
    // ------------------------------------------------------------------
    function automatic logic [SW+1:0] seg_add(
        input logic [SW-1:0] x,
        input logic [SW-1:0] y,
        input logic          ci
    );
        logic [SW-1:0] sum;
        logic          c;      // carry between blocks
        logic          bc;     // carry entering the current block
        logic          rc;     // ripple carry inside the current block
        logic          bp;     // block propagate
        logic          pb;     // bit propagate
        logic          cm;     // carry into the most recent bit
        sum = '0;
        c   = ci;
        cm  = 1'b0;
        for (int j = 0; j < BLK_PER_STG; j++) begin
            bc = c;
            rc = c;
            bp = 1'b1;
            for (int i = 0; i < BLK; i++) begin
                pb               = x[j*BLK+i] ^ y[j*BLK+i];
                sum[j*BLK+i]     = pb ^ rc;
                cm               = rc;
                rc               = (x[j*BLK+i] & y[j*BLK+i]) | (pb & rc);
                bp               = bp & pb;
            end
            c = bp ? bc : rc;
        end
        return {cm, c, sum};
    endfunction

    // ------------------------------------------------------------------
    // Datapath: stage 0 reads the ports, and stage k reads register k-1.
    // Every stage receives the full-width vectors and works on its own
    // SW-bit slice.
    // ------------------------------------------------------------------
    always_comb begin
        src_v    = '0;
        src_c    = '0;
        nxt_c    = '0;
        nxt_cm   = '0;
        res      = '0;

        src_v[0] = in_valid;
        src_a[0] = a;
        src_b[0] = b_eff;
        src_s[0] = '0;
        src_c[0] = c0;
        for (int k = 1; k < NSTG; k++) begin
            src_v[k] = v_q[k-1];
            src_a[k] = a_q[k-1];
            src_b[k] = b_q[k-1];
            src_s[k] = s_q[k-1];
            src_c[k] = c_q[k-1];
        end

        for (int k = 0; k < NSTG; k++) begin
            res                   = seg_add(src_a[k][k*SW +: SW],
                                            src_b[k][k*SW +: SW],
                                            src_c[k]);
            nxt_s[k]              = src_s[k];
            nxt_s[k][k*SW +: SW]  = res[SW-1:0];
            nxt_c[k]              = res[SW];
            nxt_cm[k]             = res[SW+1];
        end
    end

    // ------------------------------------------------------------------
    // Flow control. A stage may load when it is empty, or when its
    // occupant moves on in the same cycle. The chain runs from the output
    // back to in_ready, so a full pipe with out_ready high still takes a
    // new op every cycle.
    // ------------------------------------------------------------------
    always_comb begin
        en         = '0;
        en[NSTG-1] = !v_q[NSTG-1] || out_ready;
        for (int k = NSTG - 2; k >= 0; k--) begin
            en[k] = !v_q[k] || en[k+1];
        end
    end

    assign in_ready = en[0];

    // ------------------------------------------------------------------
    // Stage registers. Data loads only with a live op. A bubble clears
    // the valid bit and leaves the data unchanged, so s keeps its last
    // value between results.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_q <= '0;
            c_q <= '0;
            for (int k = 0; k < NSTG; k++) begin
                s_q[k]  <= '0;
                cm_q[k] <= 1'b0;
            end
            for (int k = 0; k < OPN; k++) begin
                a_q[k] <= '0;
                b_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < NSTG; k++) begin
                if (en[k]) begin
                    v_q[k] <= src_v[k];
                    if (src_v[k]) begin
                        s_q[k]  <= nxt_s[k];
                        c_q[k]  <= nxt_c[k];
                        cm_q[k] <= nxt_cm[k];
                    end
                end
            end
            for (int k = 0; k < NSTG - 1; k++) begin
                if (en[k] && src_v[k]) begin
                    a_q[k] <= src_a[k];
                    b_q[k] <= src_b[k];
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs come from the last stage register.
    // ------------------------------------------------------------------
    assign out_valid = v_q[NSTG-1];
    assign s         = s_q[NSTG-1];
    assign cout      = c_q[NSTG-1];
    assign ovf       = c_q[NSTG-1] ^ cm_q[NSTG-1];

endmodule

// File: tb/tb_pipelined_cskip_adder.sv
module tb_pipelined_cskip_adder;

  localparam int W  = 32;
  localparam int W2 = 64;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT (default: 32 bit, 4 stages) ----------------
  logic         in_valid, in_ready, c_in, sub, out_valid, out_ready, cout, ovf;
  logic [W-1:0] a, b, s;

  pipelined_cskip_adder dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .c_in(c_in), .sub(sub),
    .out_valid(out_valid), .out_ready(out_ready),
    .s(s), .cout(cout), .ovf(ovf)
  );

  // ---------------- DUT (64 bit, 8-bit blocks, 8 stages) ----------------
  logic          in_valid2, in_ready2, c_in2, sub2, out_valid2, out_ready2, cout2, ovf2;
  logic [W2-1:0] a2, b2, s2;

  pipelined_cskip_adder #(.WIDTH(64), .BLK(8), .BLK_PER_STG(1)) dut64 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid2), .in_ready(in_ready2),
    .a(a2), .b(b2), .c_in(c_in2), .sub(sub2),
    .out_valid(out_valid2), .out_ready(out_ready2),
    .s(s2), .cout(cout2), .ovf(ovf2)
  );

  // ---------------- vector table ----------------
  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         c_in;
    logic         sub;
    logic [W-1:0] s;
    logic         cout;
    logic         ovf;
  } vec_t;

  localparam int NV = 18;
  vec_t vecs [NV];

  // ---------------- scoreboard ----------------
  logic [W+1:0] exp_q[$];   // {ovf, cout, s}
  int checks = 0;
  int errors = 0;
  int n_out  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // A result transfers on the next rising edge when out_valid & out_ready.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_result", {30'd0, ovf, cout, s}, 64'hDEAD);
      end else begin
        check("result", {30'd0, ovf, cout, s}, {30'd0, exp_q.pop_front()});
      end
      n_out++;
    end
  end

  // ---------------- driver tasks (called at posedge + 1) ----------------
  task automatic drive(input int lo, input int hi, input int max_cyc, input bit push,
                       output int nacc, output int ncyc);
    int idx;
    idx  = lo;
    nacc = 0;
    ncyc = 0;
    while (idx <= hi && ncyc < max_cyc) begin
      a        = vecs[idx].a;
      b        = vecs[idx].b;
      c_in     = vecs[idx].c_in;
      sub      = vecs[idx].sub;
      in_valid = 1'b1;
      @(negedge clk);
      if (in_ready) begin
        if (push) exp_q.push_back({vecs[idx].ovf, vecs[idx].cout, vecs[idx].s});
        idx++;
        nacc++;
      end
      @(posedge clk);
      #1;
      ncyc++;
    end
    in_valid = 1'b0;
  endtask

  // One op into an empty pipe. Returns the number of falling edges, from
  // the accept edge on, until out_valid is seen.
  task automatic single_op(input int idx, output int lat);
    a        = vecs[idx].a;
    b        = vecs[idx].b;
    c_in     = vecs[idx].c_in;
    sub      = vecs[idx].sub;
    in_valid = 1'b1;
    @(negedge clk);
    check("in_ready_idle", 64'(in_ready), 64'd1);
    exp_q.push_back({vecs[idx].ovf, vecs[idx].cout, vecs[idx].s});
    @(posedge clk);
    #1;
    // Later operand changes must not reach the captured op.
    in_valid = 1'b0;
    a        = ~vecs[idx].a;
    b        = 32'h5A5A_5A5A;
    sub      = ~vecs[idx].sub;
    c_in     = ~vecs[idx].c_in;
    lat = 0;
    while (lat < 20) begin
      @(negedge clk);
      lat++;
      if (out_valid) break;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      @(posedge clk);
      n++;
    end
    #1;
    check(name, 64'(exp_q.size()), 64'd0);
    check({name, "_out_valid"}, 64'(out_valid), 64'd0);
  endtask

  task automatic op64(input string name, input logic [W2-1:0] x, input logic [W2-1:0] y,
                      input logic ci, input logic sb,
                      input logic [W2-1:0] es, input logic ec, input logic eo);
    int lat;
    a2 = x; b2 = y; c_in2 = ci; sub2 = sb; in_valid2 = 1'b1;
    @(negedge clk);
    check({name, "_in_ready"}, 64'(in_ready2), 64'd1);
    @(posedge clk);
    #1;
    in_valid2 = 1'b0;
    a2 = '0; b2 = '1;
    lat = 0;
    while (lat < 30) begin
      @(negedge clk);
      lat++;
      if (out_valid2) break;
    end
    check({name, "_latency"}, 64'(lat), 64'd8);
    check({name, "_s"}, s2, es);
    check({name, "_cout_ovf"}, {62'd0, cout2, ovf2}, {62'd0, ec, eo});
    @(posedge clk);
    #1;
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    int lat, nacc, ncyc, base;

    //          a             b             cin   sub   s             cout  ovf
    vecs[0]  = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0};
    vecs[1]  = '{32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1};
    vecs[2]  = '{32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0};
    vecs[3]  = '{32'h0000_0000, 32'h0000_0000, 1'b1, 1'b0, 32'h0000_0001, 1'b0, 1'b0};
    vecs[4]  = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1};
    vecs[5]  = '{32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b1};
    vecs[6]  = '{32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0, 32'h2345_6789, 1'b0, 1'b0};
    vecs[7]  = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0, 32'hFFFF_FFFF, 1'b1, 1'b0};
    vecs[8]  = '{32'h0000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0};
    vecs[9]  = '{32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b1, 32'h8000_0000, 1'b0, 1'b1};
    vecs[10] = '{32'h1234_5678, 32'h1234_5678, 1'b0, 1'b1, 32'h0000_0000, 1'b1, 1'b0};
    vecs[11] = '{32'h0000_0010, 32'h0000_0003, 1'b1, 1'b1, 32'h0000_000D, 1'b1, 1'b0};
    vecs[12] = '{32'h0000_000F, 32'h0000_00F0, 1'b1, 1'b0, 32'h0000_0100, 1'b0, 1'b0};
    vecs[13] = '{32'hAAAA_AAAA, 32'h5555_5555, 1'b1, 1'b0, 32'h0000_0000, 1'b1, 1'b0};
    vecs[14] = '{32'hAAAA_AAAA, 32'h5555_5555, 1'b0, 1'b0, 32'hFFFF_FFFF, 1'b0, 1'b0};
    vecs[15] = '{32'h0000_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0001_0000, 1'b0, 1'b0};
    vecs[16] = '{32'h8000_0000, 32'h7FFF_FFFF, 1'b0, 1'b1, 32'h0000_0001, 1'b1, 1'b1};
    vecs[17] = '{32'hF000_0000, 32'h1000_0000, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0};

    in_valid = 1'b0; a = '0; b = '0; c_in = 1'b0; sub = 1'b0; out_ready = 1'b0;
    in_valid2 = 1'b0; a2 = '0; b2 = '0; c_in2 = 1'b0; sub2 = 1'b0; out_ready2 = 1'b1;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_s_cout_ovf", {29'd0, ovf, cout, s}, 64'd0);
    rst_n = 1'b1;
    #1;
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_valid2", {63'd0, out_valid2}, 64'd0);
    check("rst_s2", s2, 64'd0);
    @(posedge clk);
    #1;

    // Full skip chain, latency of 4
    out_ready = 1'b1;
    single_op(0, lat);
    check("lat_add_skip", 64'(lat), 64'd4);

    // Subtraction with overflow, and with a borrow
    single_op(1, lat);
    check("lat_sub_ovf", 64'(lat), 64'd4);
    single_op(2, lat);
    check("lat_sub_borrow", 64'(lat), 64'd4);

    // Back-to-back through the whole table at one op per cycle
    base = n_out;
    drive(0, NV - 1, 100, 1'b1, nacc, ncyc);
    check("b2b_accepted", 64'(nacc), 64'(NV));
    check("b2b_cycles", 64'(ncyc), 64'(NV));
    wait_drain("b2b_drain");
    check("b2b_results", 64'(n_out - base), 64'(NV));

    // Output stall: 8 ops offered over 6 cycles, only 4 fit
    out_ready = 1'b0;
    base = n_out;
    drive(6, 13, 6, 1'b1, nacc, ncyc);
    check("stall_accepted", 64'(nacc), 64'd4);
    check("stall_in_ready", 64'(in_ready), 64'd0);
    check("stall_out_valid", 64'(out_valid), 64'd1);
    check("stall_s", 64'(s), 64'(vecs[6].s));
    repeat (2) @(posedge clk);
    #1;
    check("stall_s_hold", {29'd0, ovf, cout, s}, {29'd0, vecs[6].ovf, vecs[6].cout, vecs[6].s});
    check("stall_in_ready_hold", 64'(in_ready), 64'd0);
    out_ready = 1'b1;
    wait_drain("stall_drain");
    check("stall_results", 64'(n_out - base), 64'd4);

    // Asynchronous reset while the pipe is full
    out_ready = 1'b0;
    drive(11, 14, 5, 1'b0, nacc, ncyc);
    check("prerst_out_valid", 64'(out_valid), 64'd1);
    check("prerst_s", 64'(s), 64'(vecs[11].s));
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", 64'(out_valid), 64'd0);
    check("midrst_s_cout_ovf", {29'd0, ovf, cout, s}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("postrst_out_valid", 64'(out_valid), 64'd0);
    out_ready = 1'b1;
    single_op(4, lat);
    check("postrst_latency", 64'(lat), 64'd4);
    check("postrst_queue", 64'(exp_q.size()), 64'd0);

    // 64-bit instance with 8 stages
    op64("w64_ovf", 64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0,
         64'h8000_0000_0000_0000, 1'b0, 1'b1);
    op64("w64_carry", 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0,
         64'h0, 1'b1, 1'b0);
    op64("w64_sub", 64'h0, 64'h1, 1'b1, 1'b1,
         64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
